// File: rtl/booth_pkg.sv
// booth_pkg: shared definitions for the sequential Booth multiplier.
//   - state_t : controller states IDLE / RUN / DONE
//   - digit_t : radix-4 Booth digit (0, +1, +2, -1, -2)
//   - iter_count(width, radix4) : number of Booth steps (ITER) per product
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        ZERO = 3'd0,
        POS1 = 3'd1,
        POS2 = 3'd2,
        NEG1 = 3'd3,
        NEG2 = 3'd4
    } digit_t;

    // Radix-2 consumes one bit of the (WIDTH+1)-bit extended multiplier per
    // step; radix-4 consumes two bits of the (WIDTH+2)-bit one.
    function automatic int iter_count(input int width, input bit radix4);
        return radix4 ? (width / 2 + 1) : (width + 1);
    endfunction

endpackage

// File: rtl/booth_recoder4.sv
// booth_recoder4: combinational modified-Booth recoder.
// Ports:
//   window [2:0] : multiplier bits {q1, q0, q-1}
//   sel2x        : digit magnitude is 2 (else 1)
//   negate       : digit is negative
//   zero         : digit is 0 (overrides sel2x/negate)
module booth_recoder4
    import booth_pkg::*;
(
    input  logic [2:0] window,
    output logic       sel2x,
    output logic       negate,
    output logic       zero
);

    digit_t digit;

    always_comb begin
        digit = ZERO;
        case (window)
            3'b001, 3'b010: digit = POS1;
            3'b011:         digit = POS2;
            3'b100:         digit = NEG2;
            3'b101, 3'b110: digit = NEG1;
            default:        digit = ZERO;
        endcase
        sel2x  = (digit == POS2) || (digit == NEG2);
        negate = (digit == NEG1) || (digit == NEG2);
        zero   = (digit == ZERO);
    end

endmodule

// File: rtl/booth_mul_seq.sv
// booth_mul_seq: sequential Booth multiplier, one Booth step per clock.
// Build option: define BOOTH_RADIX4_EN for modified Booth radix-4
// (ITER = WIDTH/2+1); otherwise radix-2 (ITER = WIDTH+1).
// Ports:
//   clock        : rising-edge clock
//   clear        : synchronous active-high reset, highest priority
//   start        : request pulse; operands/signed_mode sampled on same edge
//   signed_mode  : 1 = two's-complement operands, 0 = unsigned
//   multiplicand : operand A (WIDTH bits)
//   multiplier   : operand B (WIDTH bits)
//   busy         : high while iterating (RUN)
//   done         : one-cycle pulse when hi/lo carry a new product
//   hi, lo       : product bits [2*WIDTH-1:WIDTH] and [WIDTH-1:0]
module booth_mul_seq
    import booth_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

`ifdef BOOTH_RADIX4_EN
    localparam bit RADIX4 = 1'b1;
`else
    localparam bit RADIX4 = 1'b0;
`endif

    localparam int EXT   = RADIX4 ? WIDTH + 2 : WIDTH + 1;
    localparam int ACC_W = EXT + 2;              // room for +/-2M
    localparam int SHIFT = RADIX4 ? 2 : 1;
    localparam int TOT_W = ACC_W + EXT + 1;      // {acc, q, q-1}
    localparam int ITER  = iter_count(WIDTH, RADIX4);
    localparam logic [CNT_W-1:0] ITER_CNT = CNT_W'(ITER);

    state_t             state_reg, state_next;
    logic [ACC_W-1:0]   acc_reg;
    logic [EXT-1:0]     q_reg;
    logic               qm1_reg;
    logic [EXT-1:0]     m_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [WIDTH-1:0]   hi_reg, lo_reg;

    logic               load, step;
    logic               last_step;
    logic [EXT-1:0]     ext_a, ext_b;
    logic [ACC_W-1:0]   m_acc, addend, sum;
    logic [TOT_W-1:0]   shifted;

    // Extension by one (radix-2) or two (radix-4) bits lets unsigned
    // operands be treated as positive signed values by the Booth recoding.
    assign ext_a = signed_mode ? {{(EXT-WIDTH){multiplicand[WIDTH-1]}}, multiplicand}
                               : {{(EXT-WIDTH){1'b0}}, multiplicand};
    assign ext_b = signed_mode ? {{(EXT-WIDTH){multiplier[WIDTH-1]}}, multiplier}
                               : {{(EXT-WIDTH){1'b0}}, multiplier};

    assign m_acc     = {{(ACC_W-EXT){m_reg[EXT-1]}}, m_reg};
    assign last_step = (cnt_reg == CNT_W'(1));

`ifdef BOOTH_RADIX4_EN
    logic             sel2x, negate, zero;
    logic [ACC_W-1:0] mag;

    booth_recoder4 u_recoder (
        .window ({q_reg[1:0], qm1_reg}),
        .sel2x  (sel2x),
        .negate (negate),
        .zero   (zero)
    );

    always_comb begin
        mag    = sel2x ? (m_acc << 1) : m_acc;
        addend = '0;
        if (!zero) begin
            addend = negate ? -mag : mag;
        end
    end
`else
    always_comb begin
        addend = '0;
        case ({q_reg[0], qm1_reg})
            2'b01:   addend = m_acc;
            2'b10:   addend = -m_acc;
            default: addend = '0;
        endcase
    end
`endif

    assign sum = acc_reg + addend;

    // One Booth step: add, then arithmetic shift of the whole {acc, q, q-1}.
    assign shifted = $signed({sum, q_reg, qm1_reg}) >>> SHIFT;

    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        done       = 1'b0;
        load       = 1'b0;
        step       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                step = 1'b1;
                if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            acc_reg <= '0;
            q_reg   <= '0;
            qm1_reg <= 1'b0;
            m_reg   <= '0;
            cnt_reg <= '0;
            hi_reg  <= '0;
            lo_reg  <= '0;
        end else if (load) begin
            acc_reg <= '0;
            q_reg   <= ext_b;
            qm1_reg <= 1'b0;
            m_reg   <= ext_a;
            cnt_reg <= ITER_CNT;
        end else if (step) begin
            acc_reg <= shifted[TOT_W-1 -: ACC_W];
            q_reg   <= shifted[EXT:1];
            qm1_reg <= shifted[0];
            cnt_reg <= cnt_reg - CNT_W'(1);
            // Final shift leaves the product in {acc, q}; publish its low
            // 2*WIDTH bits on the edge that enters DONE.
            if (last_step) begin
                hi_reg <= shifted[2*WIDTH:WIDTH+1];
                lo_reg <= shifted[WIDTH:1];
            end
        end
    end

    assign hi = hi_reg;
    assign lo = lo_reg;

endmodule

// File: tb/tb_booth_mul_seq.sv
// tb_booth_mul_seq: self-checking bench for booth_mul_seq (WIDTH=32).
// Directed vector table, multi-cycle corner sequences, and a random sweep
// against an arithmetic reference model. Works in both builds
// (BOOTH_RADIX4_EN defined or not).
module tb_booth_mul_seq;

    localparam int WIDTH   = 32;
    localparam int TIMEOUT = 200;
`ifdef BOOTH_RADIX4_EN
    localparam int EXP_ITER = WIDTH / 2 + 1;
`else
    localparam int EXP_ITER = WIDTH + 1;
`endif

    logic             clock;
    logic             clear;
    logic             start;
    logic             signed_mode;
    logic [WIDTH-1:0] multiplicand;
    logic [WIDTH-1:0] multiplier;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    int n_checks = 0;
    int n_pass   = 0;

    booth_mul_seq #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .clock        (clock),
        .clear        (clear),
        .start        (start),
        .signed_mode  (signed_mode),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .hi           (hi),
        .lo           (lo)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        bit          sm;
        logic [63:0] exp_p;
    } vec_t;

    vec_t vecs[10];

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                            input bit sm);
        longint sa, sb;
        if (sm) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        return {32'd0, a} * {32'd0, b};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Presents an operation for one clock; returns at the negedge after the start edge.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit sm);
        @(negedge clock);
        multiplicand = a;
        multiplier   = b;
        signed_mode  = sm;
        start        = 1'b1;
        @(negedge clock);
        start        = 1'b0;
    endtask

    // Counts edges since the start edge until done is seen (bounded).
    task automatic wait_done(input int lat0, output int lat, output int busy_cnt);
        lat      = lat0;
        busy_cnt = 0;
        while (!done && lat < TIMEOUT) begin
            if (busy) busy_cnt++;
            @(negedge clock);
            lat++;
        end
    endtask

    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input bit sm,
                         output logic [63:0] p, output int lat, output int busy_cnt);
        issue(a, b, sm);
        wait_done(0, lat, busy_cnt);
        p = {hi, lo};
    endtask

    initial begin
        logic [63:0] p, p_first, exp;
        int          lat, bcnt, done_seen;
        logic [31:0] ra, rb;
        bit          rsm;

        vecs[0] = '{"u_12x14",      32'h00000012, 32'h00000014, 1'b0, 64'h00000000_00000168};
        vecs[1] = '{"s_m3x5",       32'hFFFFFFFD, 32'h00000005, 1'b1, 64'hFFFFFFFF_FFFFFFF1};
        vecs[2] = '{"u_m3x5",       32'hFFFFFFFD, 32'h00000005, 1'b0, 64'h00000004_FFFFFFF1};
        vecs[3] = '{"u_max_sq",     32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE_00000001};
        vecs[4] = '{"s_minneg_sq",  32'h80000000, 32'h80000000, 1'b1, 64'h40000000_00000000};
        vecs[5] = '{"s_minneg_max", 32'h80000000, 32'h7FFFFFFF, 1'b1, 64'hC0000000_80000000};
        vecs[6] = '{"s_m1_sq",      32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'h00000000_00000001};
        vecs[7] = '{"zero_a",       32'h00000000, 32'h12345678, 1'b1, 64'h00000000_00000000};
        vecs[8] = '{"zero_b",       32'hDEADBEEF, 32'h00000000, 1'b0, 64'h00000000_00000000};
        vecs[9] = '{"u_7x6",        32'h00000007, 32'h00000006, 1'b0, 64'h00000000_0000002A};

        clear        = 1'b1;
        start        = 1'b0;
        signed_mode  = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        repeat (3) @(negedge clock);
        clear = 1'b0;
        check("reset_state", {30'd0, busy, done, hi, lo}, 64'd0);

        // Directed table: product, latency, busy length, single-cycle done.
        for (int i = 0; i < 10; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].sm, p, lat, bcnt);
            $display("op %s a=0x%08h b=0x%08h s=%0d -> 0x%016h lat=%0d",
                     vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].sm, p, lat);
            check({vecs[i].name, "_prod"}, p, vecs[i].exp_p);
            check({vecs[i].name, "_lat"}, 64'(lat), 64'(EXP_ITER));
            check({vecs[i].name, "_busy"}, 64'(bcnt), 64'(EXP_ITER));
            check({vecs[i].name, "_busy_in_done"}, 64'(busy), 64'd0);
            @(negedge clock);
            check({vecs[i].name, "_done_pulse"}, 64'(done), 64'd0);
        end

        // start during RUN is ignored.
        issue(32'h00000012, 32'h00000014, 1'b0);
        repeat (5) @(negedge clock);
        multiplicand = 32'h00001111;
        multiplier   = 32'h00002222;
        signed_mode  = 1'b1;
        start        = 1'b1;
        @(negedge clock);
        start        = 1'b0;
        wait_done(6, lat, bcnt);
        $display("op mid_run_start -> 0x%016h lat=%0d", {hi, lo}, lat);
        check("midrun_start_prod", {hi, lo}, 64'h168);
        check("midrun_start_lat", 64'(lat), 64'(EXP_ITER));

        // start held in the DONE cycle: back-to-back op, hi/lo held during RUN.
        p_first      = {hi, lo};
        multiplicand = 32'hFFFFFFFD;
        multiplier   = 32'h00000005;
        signed_mode  = 1'b1;
        start        = 1'b1;
        @(negedge clock);
        start        = 1'b0;
        check("b2b_busy", 64'(busy), 64'd1);
        check("b2b_hold_hilo", {hi, lo}, p_first);
        wait_done(0, lat, bcnt);
        $display("op back_to_back -> 0x%016h lat=%0d", {hi, lo}, lat);
        check("b2b_prod", {hi, lo}, 64'hFFFFFFFF_FFFFFFF1);
        check("b2b_lat", 64'(lat), 64'(EXP_ITER));

        // clear at RUN cycle 10 aborts; no done pulse afterwards.
        issue(32'h00000012, 32'h00000014, 1'b0);
        repeat (9) @(negedge clock);
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        check("clear_midrun_outs", {30'd0, busy, done, hi, lo}, 64'd0);
        done_seen = 0;
        repeat (EXP_ITER + 5) begin
            @(negedge clock);
            if (done || busy) done_seen++;
        end
        check("clear_midrun_no_done", 64'(done_seen), 64'd0);

        // clear beats start on the same edge.
        multiplicand = 32'h00000003;
        multiplier   = 32'h00000003;
        clear        = 1'b1;
        start        = 1'b1;
        @(negedge clock);
        clear        = 1'b0;
        start        = 1'b0;
        check("clear_priority_busy", 64'(busy), 64'd0);

        do_op(32'h00000007, 32'h00000006, 1'b0, p, lat, bcnt);
        $display("op after_clear 7x6 -> 0x%016h lat=%0d", p, lat);
        check("after_clear_prod", p, 64'h2A);
        check("after_clear_lat", 64'(lat), 64'(EXP_ITER));

        // Random sweep against the arithmetic model.
        for (int i = 0; i < 1000; i++) begin
            ra  = $urandom;
            rb  = $urandom;
            rsm = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 9))
                0: ra = 32'h80000000;
                1: rb = 32'hFFFFFFFF;
                2: ra = 32'h7FFFFFFF;
                default: ;
            endcase
            exp = ref_mul(ra, rb, rsm);
            do_op(ra, rb, rsm, p, lat, bcnt);
            $display("rnd %0d a=0x%08h b=0x%08h s=%0d -> 0x%016h exp 0x%016h lat=%0d",
                     i, ra, rb, rsm, p, exp, lat);
            check("rand_prod", p, exp);
            check("rand_lat", 64'(lat), 64'(EXP_ITER));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/booth_mul_seq.md
Name: booth_mul_seq

Overview:
- Sequential Booth multiplier. Parametrised successor to the datapath's single-width mul path.
- Takes two WIDTH-bit operands on a start pulse and iterates one Booth step per clock.
- Returns a 2*WIDTH-bit product split into hi/lo, feeding the HI/LO registers, in the same way Zhigh/Zlow do today.
- Supports signed and unsigned operands; radix-4 recoding is a compile-time option.

Parameters:
- WIDTH, 32, operand width in bits; must be even and at least 4.
- CNT_W, 6, iteration-counter width; must satisfy 2^CNT_W > WIDTH+1.

Ports:
- clock, input, 1, system clock; all state updates on rising edge.
- clear, input, 1, synchronous active-high reset.
- start, input, 1, request pulse; operands sampled on the same edge.
- signed_mode, input, 1, 1 = two's-complement operands, 0 = unsigned; sampled with start.
- multiplicand, input, WIDTH, operand A.
- multiplier, input, WIDTH, operand B.
- busy, output, 1, high while iterating.
- done, output, 1, single-cycle pulse when hi/lo become valid.
- hi, output, WIDTH, product bits [2*WIDTH-1:WIDTH].
- lo, output, WIDTH, product bits [WIDTH-1:0].

Behaviour:
- Reset (clear=1 at a rising edge): state=IDLE; busy=0, done=0, hi=0, lo=0; accumulator, counter and operand registers all 0. clear has priority over every other input, including start on the same edge.
- Operand extension:
  - Radix-2: operands extended to WIDTH+1 bits, sign-extended if signed_mode else zero-extended.
  - Radix-4: operands extended to WIDTH+2 bits, same rule.
- Only the low 2*WIDTH bits of the extended product are presented on hi/lo.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 loads the extended operands, clears the accumulator, loads the counter with ITER, and enters RUN.
  - start=0 holds state.
- RUN:
  - Radix-2 step: examine multiplier bit pair {q0, q-1}.
    - 01: add multiplicand.
    - 10: subtract multiplicand.
    - 00/11: no add.
    - Then arithmetic-shift {acc, q, q-1} right by 1.
  - Counter decrements each cycle. When it reaches 1 on an edge, that edge performs the last step and enters DONE.
  - busy=1 throughout RUN.
  - start while in RUN is ignored: no restart, no error.
- DONE:
  - Entered with hi/lo updated to the final product; done=1 for exactly this one cycle; busy=0.
  - Next state is IDLE, unless start=1, in which case a new operation loads and enters RUN directly. Back-to-back operation is allowed with no gap.
- Output holding: hi/lo hold the last product until the next DONE or clear. They are not disturbed during a subsequent RUN. They update only on entry to DONE.
- ITER and latency, measured from the start edge to the edge on which done=1:
  - Radix-2: ITER = WIDTH+1 (33 for WIDTH=32).
  - Radix-4: ITER = WIDTH/2+1 (17 for WIDTH=32).
- Arithmetic:
  - Accumulator is EXT+2 bits wide so that ±2·multiplicand never overflows.
  - All adds are two's complement with discard of the carry out of the MSB.
- Operand edge cases:
  - Zero multiplicand or zero multiplier: result 0 after full latency. There is no early-out; latency is fixed.
  - Most-negative signed operand (0x80000000 for WIDTH=32) must produce a correct result.
- clear mid-RUN: abort; IDLE next cycle; hi/lo zeroed; no done pulse.

Optional Feature:
- Macro: BOOTH_RADIX4_EN.
- Defined: modified Booth radix-4.
  - Each RUN cycle examines {q1, q0, q-1} and selects one of 0, ±M, ±2M.
  - Shift right by 2 per cycle; ITER = WIDTH/2+1.
- Undefined: radix-2 as above; ITER = WIDTH+1; the recoder sub-module is not instantiated.
- Port list, handshake, reset values and results are identical in both builds; only latency differs.

Decomposition:
- Package booth_pkg:
  - State encoding IDLE/RUN/DONE.
  - Radix-4 digit encoding (ZERO, POS1, POS2, NEG1, NEG2).
  - Function iter_count(width, radix4) returning ITER.
- Sub-module booth_recoder4: combinational 3-bit window to {sel2x, negate, zero}. Used only under BOOTH_RADIX4_EN.
- All sequential logic stays in booth_mul_seq.

Test Plan:
- Unsigned 0x00000012 × 0x00000014 -> hi=0x00000000, lo=0x00000168; done exactly ITER edges after start; busy high for ITER cycles.
- Signed 0xFFFFFFFD (−3) × 0x00000005 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. The same operands unsigned -> hi=0x00000004, lo=0xFFFFFFF1.
- Extremes:
  - Unsigned 0xFFFFFFFF × 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
  - Signed 0x80000000 × 0x80000000 -> hi=0x40000000, lo=0x00000000.
- start pulsed again mid-RUN with different operands -> ignored; the first result appears unchanged at the original latency. start held high in the DONE cycle -> new op begins; its done arrives exactly ITER edges later.
- clear asserted at cycle 10 of RUN -> next cycle IDLE, busy=0, hi=lo=0, no done pulse. A subsequent 7 × 6 -> lo=0x0000002A.
- Build both with and without BOOTH_RADIX4_EN; run a random 1000-vector signed/unsigned sweep against a reference model -> all products match; latency is 17 vs 33.
